// File: rtl/picosoc_mem_arbiter.sv
// Two-master round-robin arbiter for the picorv32 native memory bus,
// with a bus watchdog that ends stalled accesses with an error word.
//
// Ports:
//   clk, reset          rising-edge clock, async active-high reset
//   m0_* / m1_*         master request side (valid/ready/addr/wdata/wstrb/rdata)
//   s_*                 shared slave bus (valid/ready/addr/wdata/wstrb/rdata)
//   timeout_err         sticky watchdog flag, cleared by err_clr
//   err_addr            address of the most recent timed-out access
module picosoc_mem_arbiter #(
  parameter int unsigned TIMEOUT   = 256,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  output logic        timeout_err,
  output logic [31:0] err_addr,
  input  logic        err_clr
);

  typedef enum logic [1:0] {
    IDLE,
    GNT0,
    GNT1,
    TOUT
  } state_t;

  localparam bit          LP_WD_EN = (TIMEOUT != 0);
  localparam logic [15:0] LP_LAST  =
    (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_last;
  logic [15:0] r_cnt;
  logic        r_err;
  logic [31:0] r_err_addr;
  logic        w_tout;
  logic        w_wd_hit;

  assign timeout_err = r_err;
  assign err_addr    = r_err_addr;

  // Final stalled cycle of a granted access.
  assign w_wd_hit = LP_WD_EN && (r_cnt == LP_LAST);

  always_comb begin
    w_next   = r_state;
    w_tout   = 1'b0;
    s_valid  = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    s_wstrb  = '0;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    m0_rdata = '0;
    m1_rdata = '0;
    unique case (r_state)
      IDLE: begin
        // r_last == 1 means master 0 wins a tie.
        if (m0_valid && (!m1_valid || r_last))
          w_next = GNT0;
        else if (m1_valid)
          w_next = GNT1;
      end
      GNT0: begin
        s_valid  = m0_valid;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        s_wstrb  = m0_wstrb;
        m0_ready = s_ready && m0_valid;
        m0_rdata = m0_ready ? s_rdata : '0;
        if (!m0_valid || s_ready) begin
          w_next = IDLE;
        end else if (w_wd_hit) begin
          w_next = TOUT;
          w_tout = 1'b1;
        end
      end
      GNT1: begin
        s_valid  = m1_valid;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        s_wstrb  = m1_wstrb;
        m1_ready = s_ready && m1_valid;
        m1_rdata = m1_ready ? s_rdata : '0;
        if (!m1_valid || s_ready) begin
          w_next = IDLE;
        end else if (w_wd_hit) begin
          w_next = TOUT;
          w_tout = 1'b1;
        end
      end
      TOUT: begin
        // r_last still names the master whose access timed out.
        if (r_last) begin
          m1_ready = 1'b1;
          m1_rdata = ERR_RDATA;
        end else begin
          m0_ready = 1'b1;
          m0_rdata = ERR_RDATA;
        end
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_last     <= 1'b1;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next == GNT0)
        r_last <= 1'b0;
      else if (r_state == IDLE && w_next == GNT1)
        r_last <= 1'b1;
      if (r_state == IDLE)
        r_cnt <= '0;
      else if (LP_WD_EN && s_valid && !s_ready)
        r_cnt <= r_cnt + 16'd1;
      // A new timeout beats a simultaneous clear.
      if (w_tout) begin
        r_err      <= 1'b1;
        r_err_addr <= s_addr;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

endmodule

// File: doc/picosoc_mem_arbiter.md
Name: picosoc_mem_arbiter

Overview:
- Two-master arbiter for the native picorv32 memory bus (valid/ready/addr/wdata/wstrb/rdata).
- Shares the single SoC memory bus between the CPU (master 0) and a second master (master 1, e.g. a DMA engine). The bus feeds on-chip RAM, SPI flash, UART and iomem.
- Round-robin grant, held for one whole transaction.
- Bus watchdog: if no slave answers within TIMEOUT cycles, it terminates the access with an error word and raises a sticky error flag.

Parameters:
TIMEOUT, 256, max cycles s_valid may stay high without s_ready; 0 disables the watchdog
ERR_RDATA, 32'h DEAD_BEEF, read data returned on a timed-out access

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
m0_valid  input  1  master 0 request; held until m0_ready
m0_ready  output  1  master 0 transfer complete, one cycle
m0_addr  input  32  master 0 address
m0_wdata  input  32  master 0 write data
m0_wstrb  input  4  master 0 byte strobes; 0 = read
m0_rdata  output  32  master 0 read data, valid with m0_ready
m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata  as m0_*, for master 1
s_valid  output  1  request to the slave bus
s_ready  input  1  slave bus completion
s_addr  output  32  granted master address
s_wdata  output  32  granted master write data
s_wstrb  output  4  granted master strobes
s_rdata  input  32  slave read data
timeout_err  output  1  sticky watchdog error flag
err_addr  output  32  address of the most recent timed-out access
err_clr  input  1  clears timeout_err

Behaviour:
- Reset (async assert) values:
  - State IDLE; all of m0_ready, m1_ready, s_valid and timeout_err at 0.
  - err_addr = 0; last_grant = 1, so master 0 wins the first tie.
  - Reset asserted mid-transaction drops s_valid and both ready signals immediately; the pending access is abandoned.
- State machine: IDLE, GNT0, GNT1, TOUT.
- IDLE:
  - Only one mx_valid high: go to GNTx next edge.
  - Both high: grant the master that was not last_grant.
  - last_grant updates on entry to GNTx.
  - Arbitration latency is one cycle: s_valid first rises the cycle after mx_valid.
- GNTx:
  - s_valid = mx_valid.
  - s_addr, s_wdata and s_wstrb are combinationally muxed from master x.
  - mx_ready = s_ready; mx_rdata = s_rdata.
  - The other master's ready is 0.
  - On s_ready, return to IDLE. This forces one idle turnaround cycle between transactions, so a continuously requesting master alternates with the other when both request.
- Protocol violation: mx_valid dropping in GNTx without s_ready returns the FSM to IDLE without a ready pulse.
- Outputs outside GNTx:
  - s_addr, s_wdata and s_wstrb are 0 in IDLE and TOUT.
  - mx_rdata = 0 when ready is low.
- Watchdog:
  - The 16-bit counter (TIMEOUT < 65536) clears on entry to GNTx and increments each cycle with s_valid && !s_ready.
  - If count == TIMEOUT-1 and s_ready is low, go to TOUT, so s_valid is high for exactly TIMEOUT cycles.
  - s_ready in that same final cycle completes normally; no error.
- TOUT, which lasts one cycle:
  - s_valid = 0.
  - Granted mx_ready = 1 and mx_rdata = ERR_RDATA. Writes are dropped.
  - timeout_err set to 1 and err_addr captures s_addr, both registered on the transition into TOUT.
  - Next state IDLE.
- err_clr clears timeout_err on the next edge. If err_clr coincides with a new timeout, the set wins.
- TIMEOUT = 0: the watchdog logic is inert and TOUT is unreachable.

Test Plan:
- Read, single master: m0 reads 0x0000_0010, slave answers s_rdata=0x1234_5678 two cycles after s_valid -> s_valid rises one cycle after m0_valid; m0_ready is a single pulse with m0_rdata=0x1234_5678; m1_ready stays 0.
- Contention: m0 and m1 both request continuously, slave ready=1 immediately -> grants go m0, m1, m0, m1, with one IDLE cycle between; each master gets one transfer per 4 cycles.
- Write: m1 writes 0xAABB_CCDD with wstrb=4'b0011 to 0x0000_0200 -> s_wstrb=4'b0011, s_addr=0x200, s_wdata=0xAABB_CCDD while s_valid; m1_ready pulses with s_ready.
- Timeout: TIMEOUT=16, m0 reads 0x0300_0000, slave never readies -> s_valid high exactly 16 cycles; next cycle m0_ready=1 with m0_rdata=0xDEAD_BEEF; timeout_err=1; err_addr=0x0300_0000.
- Error clear: assert err_clr for one cycle -> timeout_err=0. Repeat the timeout with err_clr held high in the TOUT-entry cycle -> timeout_err=1.
- Reset mid-transaction: assert reset while in GNT1 with s_valid high -> s_valid, m1_ready and timeout_err go 0 without waiting for clk. After release with both masters requesting, m0 is granted first.
